cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/rr_multi_pick.sv | 66 ++++++
 rtl/cdb_arbiter.sv | 120 ++++++++++++
 tb/tb_cdb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  // Global core configuration; only the result width is consumed here.
  typedef struct packed {
    int XLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{XLEN: 32};

  // Default producer/lane counts: 4 ALUs, one LSU, one MDU onto 4 lanes.
  localparam int CdbNReqDefault = 6;
  localparam int CdbWDefault    = 4;
  localparam int CdbTagWDefault = 6;

  // One result as it travels from a producer to the bus.
  typedef struct packed {
    logic [CdbTagWDefault-1:0] tag;
    logic [31:0]               value;
  } cdb_req_t;

  // Index width for an n-entry table, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_pick.sv
// Round-robin multi-grant picker: walks the valid vector starting at the
// pointer and hands out up to CDB_W grants, one per output lane, in scan
// order. Purely combinational.
module rr_multi_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = CdbNReqDefault,
  parameter int CDB_W = CdbWDefault,
  parameter int IDXW  = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0]           i_valid,
  input  logic [IDXW-1:0]            i_rr_ptr,
  output logic [N_REQ-1:0]           o_grant,
  output logic [CDB_W-1:0]           o_lane_vld,
  output logic [CDB_W-1:0][IDXW-1:0] o_lane_idx,
  output logic                       o_any,
  output logic [IDXW-1:0]            o_next_ptr
);

  localparam int CW = $clog2(CDB_W + 1);
  localparam int SW = IDXW + 1;

  logic [SW-1:0]   w_sum;
  logic [IDXW-1:0] w_idx;
  logic [IDXW-1:0] w_last;
  logic [CW-1:0]   w_cnt;

  // Scan from the pointer with wrap, filling lanes 0,1,.. with the first hits.
  always_comb begin
    o_grant    = '0;
    o_lane_vld = '0;
    o_lane_idx = '0;
    w_sum      = '0;
    w_idx      = '0;
    w_last     = '0;
    w_cnt      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_sum = {1'b0, i_rr_ptr} + SW'(off);
      if (w_sum >= SW'(N_REQ)) begin
        w_sum = w_sum - SW'(N_REQ);
      end
      w_idx = w_sum[IDXW-1:0];
      if (i_valid[w_idx] && (w_cnt < CW'(CDB_W))) begin
        o_grant[w_idx] = 1'b1;
        for (int k = 0; k < CDB_W; k++) begin
          if (CW'(k) == w_cnt) begin
            o_lane_vld[k] = 1'b1;
            o_lane_idx[k] = w_idx;
          end
        end
        w_cnt  = w_cnt + CW'(1);
        w_last = w_idx;
      end
    end
    o_any = |o_grant;
    // Next scan starts just past the last winner; hold when nothing won.
    if (!o_any) begin
      o_next_ptr = i_rr_ptr;
    end else if (w_last == IDXW'(N_REQ - 1)) begin
      o_next_ptr = '0;
    end else begin
      o_next_ptr = w_last + IDXW'(1);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: each producer parks one result in its own holding
// buffer; every cycle up to CDB_W buffered results are broadcast, chosen
// round-robin so no producer starves. CDB_W must not exceed N_REQ.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter cfg_t Cfg    = EmptyCfg,
  parameter int   N_REQ  = CdbNReqDefault,
  parameter int   CDB_W  = CdbWDefault,
  parameter int   TAG_W  = CdbTagWDefault,
  parameter int   DATA_W = Cfg.XLEN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  input  logic [N_REQ-1:0][TAG_W-1:0]       req_tag_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]      req_val_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  output logic [CDB_W-1:0]                  cdb_valid_o,
  output logic [CDB_W-1:0][TAG_W-1:0]       cdb_tag_o,
  output logic [CDB_W-1:0][DATA_W-1:0]      cdb_val_o,
  output logic [$clog2(N_REQ+1)-1:0]        pending_o
);

  localparam int IDXW = idx_w(N_REQ);
  localparam int PW   = $clog2(N_REQ + 1);

  logic [N_REQ-1:0]              r_buf_vld;
  logic [N_REQ-1:0][TAG_W-1:0]   r_buf_tag;
  logic [N_REQ-1:0][DATA_W-1:0]  r_buf_val;
  logic [IDXW-1:0]               r_rr_ptr;

  logic [N_REQ-1:0]              w_grant;
  logic [CDB_W-1:0]              w_lane_vld;
  logic [CDB_W-1:0][IDXW-1:0]    w_lane_idx;
  logic                          w_any;
  logic [IDXW-1:0]               w_next_ptr;
  logic [N_REQ-1:0]              w_hs;

  // Arbitration looks only at registered buffer state and the pointer.
  rr_multi_pick #(
    .N_REQ (N_REQ),
    .CDB_W (CDB_W),
    .IDXW  (IDXW)
  ) u_pick (
    .i_valid    (r_buf_vld),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_lane_vld (w_lane_vld),
    .o_lane_idx (w_lane_idx),
    .o_any      (w_any),
    .o_next_ptr (w_next_ptr)
  );

  // A buffer can take a new result when empty or draining this cycle;
  // independent of req_valid_i so producers may wait on it freely.
  assign req_ready_o = (~r_buf_vld | w_grant) & {N_REQ{~flush_i}};
  assign w_hs        = req_valid_i & req_ready_o;

  // Buffer occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_vld <= '0;
      r_rr_ptr  <= '0;
    end else if (flush_i) begin
      r_buf_vld <= '0;
      r_rr_ptr  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_hs[i]) begin
          r_buf_vld[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_buf_vld[i] <= 1'b0;
        end
      end
      if (w_any) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  // Payload capture on handshake; a write wins over a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_tag <= '0;
      r_buf_val <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_hs[i]) begin
          r_buf_tag[i] <= req_tag_i[i];
          r_buf_val[i] <= req_val_i[i];
        end
      end
    end
  end

  // Lane k carries the k-th winner; idle lanes and flush cycles drive zeros.
  always_comb begin
    cdb_valid_o = '0;
    cdb_tag_o   = '0;
    cdb_val_o   = '0;
    for (int k = 0; k < CDB_W; k++) begin
      if (w_lane_vld[k] && !flush_i) begin
        cdb_valid_o[k] = 1'b1;
        cdb_tag_o[k]   = r_buf_tag[w_lane_idx[k]];
        cdb_val_o[k]   = r_buf_val[w_lane_idx[k]];
      end
    end
  end

  // Occupied-buffer count.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pending_o = pending_o + PW'(r_buf_vld[i]);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table plus reset and scoreboard sequences for cdb_arbiter.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 6;
  localparam int C  = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [N-1:0]           rv;
  logic [N-1:0][TW-1:0]   rtag;
  logic [N-1:0][DW-1:0]   rval;
  logic [N-1:0]           rdy;
  logic [C-1:0]           cv;
  logic [C-1:0][TW-1:0]   ctag;
  logic [C-1:0][DW-1:0]   cval;
  logic [2:0]             pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .N_REQ (N),
    .CDB_W (C),
    .TAG_W (TW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .req_valid_i(rv),
    .req_tag_i  (rtag),
    .req_val_i  (rval),
    .req_ready_o(rdy),
    .cdb_valid_o(cv),
    .cdb_tag_o  (ctag),
    .cdb_val_o  (cval),
    .pending_o  (pend)
  );

  function automatic logic [DW-1:0] vof(input logic [TW-1:0] t);
    return {26'd0, t} ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic                 f;
    logic [N-1:0]         rv;
    int                   base;
    logic [C-1:0]         ecv;
    logic [C-1:0][TW-1:0] etag;
    logic [N-1:0]         erdy;
    logic [2:0]           epend;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic [N-1:0] v, input int base,
                              input logic [C-1:0] ecv, input int t0, input int t1,
                              input int t2, input int t3, input logic [N-1:0] erdy,
                              input int ep);
    vec_t r;
    r.f     = f;
    r.rv    = v;
    r.base  = base;
    r.ecv   = ecv;
    r.etag  = {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
    r.erdy  = erdy;
    r.epend = 3'(ep);
    return r;
  endfunction

  task automatic drive(input logic f, input logic [N-1:0] v, input int base);
    flush = f;
    rv    = v;
    for (int i = 0; i < N; i++) begin
      rtag[i] = TW'(base + i);
      rval[i] = vof(rtag[i]);
    end
  endtask

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] val;
    int            age;
  } sb_t;

  vec_t          tbl[16];
  sb_t           sbq[$];
  logic [N-1:0]  hs_last;
  logic [TW-1:0] next_tag;
  bit            found;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 0);

    tbl[0]  = mk(0, 6'b000000,  0, 4'b0000,  0,  0,  0,  0, 6'b111111, 0);
    tbl[1]  = mk(0, 6'b100101, 10, 4'b0000,  0,  0,  0,  0, 6'b111111, 0);
    tbl[2]  = mk(0, 6'b000000,  0, 4'b0111, 10, 12, 15,  0, 6'b111111, 3);
    tbl[3]  = mk(0, 6'b111111, 20, 4'b0000,  0,  0,  0,  0, 6'b111111, 0);
    tbl[4]  = mk(0, 6'b001111, 30, 4'b1111, 20, 21, 22, 23, 6'b001111, 6);
    tbl[5]  = mk(0, 6'b000000,  0, 4'b1111, 24, 25, 30, 31, 6'b110011, 6);
    tbl[6]  = mk(0, 6'b000000,  0, 4'b0011, 32, 33,  0,  0, 6'b111111, 2);
    tbl[7]  = mk(0, 6'b010010, 40, 4'b0000,  0,  0,  0,  0, 6'b111111, 0);
    tbl[8]  = mk(0, 6'b000010, 32, 4'b0011, 44, 41,  0,  0, 6'b111111, 2);
    tbl[9]  = mk(0, 6'b000000,  0, 4'b0001, 33,  0,  0,  0, 6'b111111, 1);
    tbl[10] = mk(0, 6'b111110, 50, 4'b0000,  0,  0,  0,  0, 6'b111111, 0);
    tbl[11] = mk(1, 6'b000001, 60, 4'b0000,  0,  0,  0,  0, 6'b000000, 5);
    tbl[12] = mk(0, 6'b000000,  0, 4'b0000,  0,  0,  0,  0, 6'b111111, 0);
    tbl[13] = mk(0, 6'b111111, 10, 4'b0000,  0,  0,  0,  0, 6'b111111, 0);
    tbl[14] = mk(0, 6'b000000,  0, 4'b1111, 10, 11, 12, 13, 6'b001111, 6);
    tbl[15] = mk(0, 6'b000000,  0, 4'b0011, 14, 15,  0,  0, 6'b111111, 2);

    // Outputs while held in reset.
    #12;
    check("rst_cdb_valid", 64'(cv), 64'h0);
    check("rst_cdb_tag", 64'(ctag), 64'h0);
    check("rst_pending", 64'(pend), 64'h0);
    check("rst_ready", 64'(rdy), 64'h3F);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int s = 0; s < 16; s++) begin
      drive(tbl[s].f, tbl[s].rv, tbl[s].base);
      @(negedge clk);
      check($sformatf("s%0d_cdb_valid", s), 64'(cv), 64'(tbl[s].ecv));
      check($sformatf("s%0d_cdb_tag", s), 64'(ctag), 64'(tbl[s].etag));
      for (int k = 0; k < C; k++) begin
        check($sformatf("s%0d_lane%0d_val", s, k), 64'(cval[k]),
              tbl[s].ecv[k] ? 64'(vof(tbl[s].etag[k])) : 64'h0);
      end
      check($sformatf("s%0d_ready", s), 64'(rdy), 64'(tbl[s].erdy));
      check($sformatf("s%0d_pending", s), 64'(pend), 64'(tbl[s].epend));
      @(posedge clk); #1;
    end

    // Asynchronous reset between edges with every buffer loaded.
    drive(1'b0, 6'b111111, 20);
    @(posedge clk); #1;
    drive(1'b0, 6'b000000, 0);
    check("pre_rst_pending", 64'(pend), 64'd6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cdb_valid", 64'(cv), 64'h0);
    check("mid_rst_pending", 64'(pend), 64'h0);
    check("mid_rst_ready", 64'(rdy), 64'h3F);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_pending", 64'(pend), 64'h0);
    @(negedge clk);
    check("post_rst_cdb_valid", 64'(cv), 64'h0);
    @(posedge clk); #1;

    // Random stress against a scoreboard of accepted results.
    hs_last  = '0;
    next_tag = 6'd1;
    for (int cyc = 0; cyc < 308; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (hs_last[i]) rv[i] = 1'b0;
        if (!rv[i] && cyc < 300 && $urandom_range(0, 9) < 7) begin
          rv[i]   = 1'b1;
          rtag[i] = next_tag;
          rval[i] = vof(next_tag) ^ DW'($urandom_range(0, 255) << 16);
          next_tag = next_tag + 6'd1;
        end
      end
      @(negedge clk);
      for (int k = 0; k < C; k++) begin
        if (cv[k]) begin
          found = 1'b0;
          for (int j = 0; j < sbq.size(); j++) begin
            if (!found && sbq[j].tag == ctag[k]) begin
              found = 1'b1;
              check("sb_lane_val", 64'(cval[k]), 64'(sbq[j].val));
              sbq.delete(j);
            end
          end
          check("sb_lane_sourced", 64'(found), 64'h1);
        end
      end
      for (int j = 0; j < sbq.size(); j++) begin
        sbq[j].age++;
        check("sb_wait_bound", 64'(sbq[j].age <= 1), 64'h1);
      end
      hs_last = rv & rdy;
      for (int i = 0; i < N; i++) begin
        if (hs_last[i]) sbq.push_back('{tag: rtag[i], val: rval[i], age: 0});
      end
      @(posedge clk); #1;
    end
    check("sb_drained", 64'(sbq.size()), 64'h0);
    check("sb_pending_end", 64'(pend), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
